// File: rtl/user_mgr_obi_mux_pkg.sv
// Shared types for the user-domain OBI manager mux: manager slot naming and OBI channel structs.
package user_mgr_obi_mux_pkg;

    localparam int unsigned NumUserMgr = 2;

    typedef logic [$clog2(NumUserMgr)-1:0] user_mgr_idx_t;

    typedef enum user_mgr_idx_t {
        USER_MGR_CORE = 0,
        USER_MGR_DMA  = 1
    } user_mgr_outputs_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } mgr_obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } mgr_obi_rsp_t;

    // Index width that stays legal for a single manager.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/user_mgr_obi_mux_idx_fifo.sv
// In-order FIFO of issuing-manager indices, one entry per outstanding downstream transaction.
module user_mgr_obi_mux_idx_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           data_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/user_mgr_obi_mux.sv
// N-to-1 OBI manager mux with request lock and in-order response routing.
// USER_MGR_OBI_MUX_RR_EN selects round-robin arbitration; otherwise fixed priority (lowest index).
module user_mgr_obi_mux
    import user_mgr_obi_mux_pkg::*;
#(
    parameter int unsigned NumMgr      = 2,
    parameter int unsigned NumMaxTrans = 2,
    parameter type         obi_req_t   = mgr_obi_req_t,
    parameter type         obi_rsp_t   = mgr_obi_rsp_t
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  obi_req_t [NumMgr-1:0]            sbr_req_i,
    output obi_rsp_t [NumMgr-1:0]            sbr_rsp_o,
    output obi_req_t                         mgr_req_o,
    input  obi_rsp_t                         mgr_rsp_i,
    output logic [$clog2(NumMaxTrans+1)-1:0] outstanding_o
);

    localparam int unsigned IdxW = idx_width(NumMgr);

    logic [NumMgr-1:0] req_vec;
    logic [IdxW-1:0]   arb_idx, win_idx, head_idx;
    logic [IdxW-1:0]   lock_idx_q, lock_idx_d;
    logic              lock_q, lock_d;
    logic              fifo_full, fifo_empty, hs, pop;

    always_comb begin
        req_vec = '0;
        for (int i = 0; i < NumMgr; i++) req_vec[i] = sbr_req_i[i].req;
    end

`ifdef USER_MGR_OBI_MUX_RR_EN
    logic [IdxW-1:0] rr_q, rr_d;
    int unsigned     cand;
    logic            found;

    // Search starts at the pointer and wraps around once.
    always_comb begin
        arb_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < NumMgr; k++) begin
            cand = (int'(rr_q) + k) % NumMgr;
            if (!found && req_vec[cand]) begin
                found   = 1'b1;
                arb_idx = IdxW'(cand);
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (hs) rr_d = (win_idx == IdxW'(NumMgr - 1)) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rr_q <= '0;
        else       rr_q <= rr_d;
    end
`else
    always_comb begin
        arb_idx = '0;
        for (int i = NumMgr - 1; i >= 0; i--) begin
            if (req_vec[i]) arb_idx = IdxW'(i);
        end
    end
`endif

    // A pending, ungranted request keeps its slot until the handshake.
    assign win_idx = lock_q ? lock_idx_q : arb_idx;

    always_comb begin
        mgr_req_o     = sbr_req_i[win_idx];
        mgr_req_o.req = sbr_req_i[win_idx].req & ~fifo_full & ~rst_i;
    end

    assign hs  = mgr_req_o.req & mgr_rsp_i.gnt;
    assign pop = mgr_rsp_i.rvalid & ~fifo_empty & ~rst_i;

    always_comb begin
        for (int i = 0; i < NumMgr; i++) begin
            sbr_rsp_o[i]        = mgr_rsp_i;
            sbr_rsp_o[i].gnt    = hs && (win_idx == IdxW'(i));
            sbr_rsp_o[i].rvalid = pop && (head_idx == IdxW'(i));
        end
    end

    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (hs) begin
            lock_d = 1'b0;
        end else if (mgr_req_o.req) begin
            lock_d     = 1'b1;
            lock_idx_d = win_idx;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    user_mgr_obi_mux_idx_fifo #(
        .Depth (NumMaxTrans),
        .Width (IdxW)
    ) i_idx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (hs),
        .data_i  (win_idx),
        .pop_i   (pop),
        .head_o  (head_idx),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o)
    );

`ifndef SYNTHESIS
    // A response with nothing outstanding is dropped; flag it so the bad subordinate is noticed.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(mgr_rsp_i.rvalid && fifo_empty))
            else $warning("user_mgr_obi_mux: rvalid with no outstanding transaction, dropped");
        end
    end
`endif

endmodule

// File: tb/tb_user_mgr_obi_mux.sv
// Bench for user_mgr_obi_mux: directed scenarios plus random traffic against a queue-based model.
module tb_user_mgr_obi_mux;
    import user_mgr_obi_mux_pkg::*;

    localparam int N = 2;
    localparam int D = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    mgr_obi_req_t [N-1:0] sbr_req;
    mgr_obi_rsp_t [N-1:0] sbr_rsp;
    mgr_obi_req_t         mgr_req;
    mgr_obi_rsp_t         mgr_rsp;
    logic [1:0]           outstanding;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: issuing-index queue, lock, round-robin pointer.
    int       m_q[$];
    bit       m_lock;
    int       m_lock_idx;
    int       m_rr;
    bit [N-1:0] gnt_seen;

    always #5 clk = ~clk;

    user_mgr_obi_mux #(
        .NumMgr      (N),
        .NumMaxTrans (D)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .sbr_req_i     (sbr_req),
        .sbr_rsp_o     (sbr_rsp),
        .mgr_req_o     (mgr_req),
        .mgr_rsp_i     (mgr_rsp),
        .outstanding_o (outstanding)
    );

    task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic int pick(input bit [N-1:0] r);
        if (m_lock) return m_lock_idx;
`ifdef USER_MGR_OBI_MUX_RR_EN
        for (int k = 0; k < N; k++) if (r[(m_rr + k) % N]) return (m_rr + k) % N;
`else
        for (int k = 0; k < N; k++) if (r[k]) return k;
`endif
        return 0;
    endfunction

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        bit [N-1:0] r;
        int  win;
        bit  exp_req, pop, hs;
        if (rst) begin
            chk("rst_req", mgr_req.req, 0);
            chk("rst_outstanding", outstanding, 0);
            chk("rst_gnt_rvalid", {sbr_rsp[1].gnt, sbr_rsp[0].gnt, sbr_rsp[1].rvalid, sbr_rsp[0].rvalid}, 0);
            m_q.delete();
            m_lock = 0;
            m_lock_idx = 0;
            m_rr = 0;
            gnt_seen = '0;
        end else begin
            for (int i = 0; i < N; i++) r[i] = sbr_req[i].req;
            win     = pick(r);
            exp_req = (m_q.size() < D) && (m_lock ? r[m_lock_idx] : (r != '0));
            hs      = exp_req && mgr_rsp.gnt;
            pop     = mgr_rsp.rvalid && (m_q.size() > 0);
            chk("req", mgr_req.req, exp_req);
            if (exp_req) chk("a_chan", mgr_req.a, sbr_req[win].a);
            chk("outstanding", outstanding, m_q.size());
            for (int i = 0; i < N; i++) begin
                chk("gnt", sbr_rsp[i].gnt, hs && (win == i));
                chk("rvalid", sbr_rsp[i].rvalid, pop && (m_q[0] == i));
                chk("r_bcast", sbr_rsp[i].r, mgr_rsp.r);
                gnt_seen[i] = sbr_rsp[i].gnt;
            end
            if (pop) void'(m_q.pop_front());
            if (hs) begin
                m_q.push_back(win);
                m_lock = 0;
                m_rr = (win + 1) % N;
            end else if (exp_req) begin
                m_lock = 1;
                m_lock_idx = win;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] addr);
        sbr_req[i].req     = 1'b1;
        sbr_req[i].a.addr  = addr;
        sbr_req[i].a.we    = 1'b0;
        sbr_req[i].a.be    = 4'hf;
        sbr_req[i].a.wdata = 32'h0;
    endtask

    task automatic drain();
        sbr_req[0].req = 1'b0;
        sbr_req[1].req = 1'b0;
        mgr_rsp.gnt    = 1'b0;
        for (int k = 0; k < 8 && m_q.size() > 0; k++) begin
            mgr_rsp.rvalid = 1'b1;
            nxt();
        end
        mgr_rsp.rvalid = 1'b0;
        chk("drain_empty", m_q.size(), 0);
        nxt();
    endtask

    initial begin
        int g, prev;
        rst     = 1'b1;
        sbr_req = '0;
        mgr_rsp = '0;
        set_req(0, 32'h1000_0000);
        set_req(1, 32'h1000_0100);
        @(negedge clk);
        chk("reset_req_low", mgr_req.req, 0);
        nxt(); nxt();
        rst = 1'b0;
        mgr_rsp.gnt = 1'b1;
        @(negedge clk);
        chk("post_rst_addr", mgr_req.a.addr, 32'h1000_0000);
        chk("post_rst_outstanding", outstanding, 0);
        chk("post_rst_gnt0", sbr_rsp[0].gnt, 1);
        nxt();
        drain();

        // Single read from manager 1.
        set_req(1, 32'h2000_0010);
        mgr_rsp.gnt = 1'b1;
        @(negedge clk);
        chk("rd1_gnt", sbr_rsp[1].gnt, 1);
        chk("rd1_addr", mgr_req.a.addr, 32'h2000_0010);
        nxt();
        sbr_req[1].req = 1'b0;
        mgr_rsp.gnt = 1'b0;
        mgr_rsp.rvalid = 1'b1;
        mgr_rsp.r.rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("rd1_out1", outstanding, 1);
        chk("rd1_rvalid1", sbr_rsp[1].rvalid, 1);
        chk("rd1_rvalid0", sbr_rsp[0].rvalid, 0);
        chk("rd1_rdata", sbr_rsp[1].r.rdata, 32'hCAFE_F00D);
        nxt();
        mgr_rsp.rvalid = 1'b0;
        @(negedge clk);
        chk("rd1_out0", outstanding, 0);
        nxt();

        // Lock: manager 0 waits three cycles without grant, manager 1 joins meanwhile.
        set_req(0, 32'h4000_0000);
        @(negedge clk);
        chk("lock_c1", mgr_req.a.addr, 32'h4000_0000);
        nxt();
        set_req(1, 32'h4000_1000);
        @(negedge clk);
        chk("lock_c2", mgr_req.a.addr, 32'h4000_0000);
        nxt();
        @(negedge clk);
        chk("lock_c3", mgr_req.a.addr, 32'h4000_0000);
        nxt();
        mgr_rsp.gnt = 1'b1;
        @(negedge clk);
        chk("lock_gnt0", {sbr_rsp[1].gnt, sbr_rsp[0].gnt}, 2'b01);
        nxt();
        sbr_req[0].req = 1'b0;
        mgr_rsp.rvalid = 1'b1;
        @(negedge clk);
        chk("lock_gnt1", {sbr_rsp[1].gnt, sbr_rsp[0].gnt}, 2'b10);
        chk("lock_rsp0", sbr_rsp[0].rvalid, 1);
        nxt();
        drain();

        // Both requesting continuously with immediate grant and next-cycle response.
        set_req(0, 32'h5000_0000);
        set_req(1, 32'h5000_1000);
        mgr_rsp.gnt = 1'b1;
        prev = -1;
        for (int k = 0; k < 8; k++) begin
            mgr_rsp.rvalid = (m_q.size() > 0);
            @(negedge clk);
            g = sbr_rsp[1].gnt ? 1 : 0;
`ifdef USER_MGR_OBI_MUX_RR_EN
            if (prev >= 0) chk("rr_alternate", g, 1 - prev);
`else
            chk("fp_idx0", g, 0);
`endif
            prev = g;
            nxt();
        end
        drain();

        // Outstanding limit with responses withheld.
        set_req(1, 32'h3000_0000);
        mgr_rsp.gnt = 1'b1;
        nxt();
        sbr_req[1].req = 1'b0;
        set_req(0, 32'h3000_0004);
        nxt();
        set_req(0, 32'h3000_0008);
        @(negedge clk);
        chk("full_req", mgr_req.req, 0);
        chk("full_outstanding", outstanding, 2);
        chk("full_gnt0", sbr_rsp[0].gnt, 0);
        nxt();
        mgr_rsp.rvalid = 1'b1;
        mgr_rsp.r.rdata = 32'h1111_1111;
        @(negedge clk);
        chk("no_bypass_req", mgr_req.req, 0);
        chk("full_rsp_order1", {sbr_rsp[1].rvalid, sbr_rsp[0].rvalid}, 2'b10);
        nxt();
        mgr_rsp.r.rdata = 32'h2222_2222;
        @(negedge clk);
        chk("released_gnt0", sbr_rsp[0].gnt, 1);
        chk("full_rsp_order2", {sbr_rsp[1].rvalid, sbr_rsp[0].rvalid}, 2'b01);
        chk("released_out", outstanding, 1);
        nxt();
        drain();

        // Spurious response with nothing outstanding.
        mgr_rsp.rvalid = 1'b1;
        @(negedge clk);
        chk("spurious_rvalid", {sbr_rsp[1].rvalid, sbr_rsp[0].rvalid}, 2'b00);
        chk("spurious_out", outstanding, 0);
        nxt();
        mgr_rsp.rvalid = 1'b0;

        // Reset pulse with two transactions outstanding.
        set_req(0, 32'h6000_0000);
        mgr_rsp.gnt = 1'b1;
        nxt(); nxt();
        sbr_req[0].req = 1'b0;
        mgr_rsp.gnt = 1'b0;
        @(negedge clk);
        chk("pre_rst_out", outstanding, 2);
        nxt();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out", outstanding, 0);
        nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_out", outstanding, 0);
        nxt();

        // Random traffic; requests stay stable until granted.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(sbr_req[i].req && !gnt_seen[i])) begin
                    sbr_req[i].req     = ($urandom_range(0, 9) < 6);
                    sbr_req[i].a.addr  = $urandom;
                    sbr_req[i].a.we    = 1'($urandom);
                    sbr_req[i].a.be    = 4'($urandom);
                    sbr_req[i].a.wdata = $urandom;
                end
            end
            mgr_rsp.gnt     = ($urandom_range(0, 3) != 0);
            mgr_rsp.rvalid  = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            mgr_rsp.r.rdata = $urandom;
            mgr_rsp.r.err   = 1'($urandom);
            nxt();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
